ahb_sram_slave: RTL

- AHB-Lite responder (slave end) hosting a byte-addressable on-chip SRAM.
- Attaches to one slave port of the AHB interconnect.
- haddr arrives already rebased to a zero offset by the interconnect.
- Supports 32-bit data with byte, halfword and word transfers, read-after-write forwarding, and a two-cycle ERROR response for illegal accesses.

---
 rtl/ahb_pkg.sv | 31 +++
 rtl/ahb_sram_array.sv | 30 +++
 rtl/ahb_sram_slave.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer types, size codes, response codes and
// the byte-lane decode used by every 32-bit slave on the bus.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef logic [2:0] hsize_t;

  localparam hsize_t HSIZE_BYTE = 3'b000;
  localparam hsize_t HSIZE_HALF = 3'b001;
  localparam hsize_t HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Little-endian lane enables for a 32-bit bus; unsupported sizes give no lanes.
  function automatic logic [3:0] lane_mask(input hsize_t size, input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
      HSIZE_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lane_mask = 4'b1111;
      default:    lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Synchronous 32-bit RAM with per-byte write enables. Reads and writes use
// independent addresses on the same edge; a same-word read returns old data.
module ahb_sram_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  // NOTE: storage has no reset; contents are undefined until written.
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: zero-wait pipelined access, read-after-write forwarding,
// two-cycle ERROR. Define AHB_SRAM_WAIT_EN to insert WAIT_STATES per transfer.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_STATES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hmastlock,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int MEM_AW = $clog2(MEM_BYTES);
  localparam int WAW    = MEM_AW - 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_ERR1 = 3'd2,
    ST_ERR2 = 3'd3
`ifdef AHB_SRAM_WAIT_EN
    , ST_WAIT = 3'd4
`endif
  } state_t;

  state_t          r_state, w_next, w_after_addr;
  logic [WAW-1:0]  r_waddr;
  logic            r_write, r_legal;
  logic [3:0]      r_mask;
  logic            r_fwd_sel;
  logic [3:0]      r_fwd_mask;
  logic [DATA_WIDTH-1:0] r_fwd_data;

  logic            w_accept, w_legal, w_commit, w_fwd_hit, w_re;
  logic [WAW-1:0]  w_haddr_word, w_raddr;
  logic [DATA_WIDTH-1:0] w_ram_q, w_merged;
  logic            w_unused;

  assign w_unused = &{1'b0, hburst, hprot, hmastlock};

`ifdef AHB_SRAM_WAIT_EN
  assign hreadyout = (r_state != ST_ERR1) && (r_state != ST_WAIT);
`else
  assign hreadyout = (r_state != ST_ERR1);
`endif

  assign w_accept     = hsel && hready && htrans[1] && hreadyout;
  assign w_haddr_word = haddr[MEM_AW-1:2];
  assign w_legal      = (hsize <= HSIZE_WORD)
                     && !((hsize == HSIZE_HALF) && haddr[0])
                     && !((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00))
                     && (haddr < ADDR_WIDTH'(MEM_BYTES));

  // A write never commits on the edge that applies reset.
  assign w_commit  = (r_state == ST_DATA) && r_write && r_legal && !HRESET;
  assign w_fwd_hit = w_commit && !hwrite && (w_haddr_word == r_waddr);

`ifdef AHB_SRAM_WAIT_EN
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge HCLK) begin
    if (HRESET)                              r_cnt <= '0;
    else if (w_accept)                       r_cnt <= CNT_W'(WAIT_STATES - 1);
    else if (r_state == ST_WAIT && r_cnt != 0) r_cnt <= r_cnt - 1'b1;
  end

  // The last WAIT cycles re-read so DATA sees any write that just committed.
  assign w_raddr = (r_state == ST_WAIT) ? r_waddr : w_haddr_word;
  assign w_re    = w_accept || (r_state == ST_WAIT);
  assign w_after_addr = !w_accept ? ST_IDLE : (w_legal ? ST_WAIT : ST_ERR1);
`else
  localparam int unused_wait_states = WAIT_STATES;
  assign w_raddr = w_haddr_word;
  assign w_re    = w_accept;
  assign w_after_addr = !w_accept ? ST_IDLE : (w_legal ? ST_DATA : ST_ERR1);
`endif

  ahb_sram_array #(.DEPTH(MEM_BYTES / 4)) u_array (
    .clk     (HCLK),
    .i_we    (w_commit),
    .i_be    (r_mask),
    .i_waddr (r_waddr),
    .i_wdata (hwdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state    <= ST_IDLE;
      r_waddr    <= '0;
      r_write    <= 1'b0;
      r_legal    <= 1'b0;
      r_mask     <= '0;
      r_fwd_sel  <= 1'b0;
      r_fwd_mask <= '0;
      r_fwd_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_waddr    <= w_haddr_word;
        r_write    <= hwrite;
        r_legal    <= w_legal;
        r_mask     <= lane_mask(hsize, haddr[1:0]);
        r_fwd_sel  <= w_fwd_hit;
        r_fwd_mask <= r_mask;
        r_fwd_data <= hwdata;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    w_next = w_after_addr;
    hresp  = HRESP_OKAY;
    case (r_state)
      ST_ERR1: begin
        w_next = ST_ERR2;
        hresp  = HRESP_ERROR;
      end
      ST_ERR2: hresp = HRESP_ERROR;
`ifdef AHB_SRAM_WAIT_EN
      ST_WAIT: w_next = (r_cnt == 0) ? ST_DATA : ST_WAIT;
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_merged = w_ram_q;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (r_fwd_sel && r_fwd_mask[b]) w_merged[8*b +: 8] = r_fwd_data[8*b +: 8];
    end
  end

  assign hrdata = (r_state == ST_DATA && !r_write && r_legal) ? w_merged : '0;

endmodule
